// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - four-way round-robin arbiter feeding a one-entry valid/ready output register
// Optional burst-mode priority hold is built with RR_MUX_LOCK_EN defined.
module rr_mux_arbiter #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [n-1:0] D0,
    input  logic [n-1:0] D1,
    input  logic [n-1:0] D2,
    input  logic [n-1:0] D3,
`ifdef RR_MUX_LOCK_EN
    input  logic         lock,
`endif
    output logic [3:0]   ack,
    output logic [n-1:0] out,
    output logic [1:0]   sel,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [1:0]   ptr;
    logic [1:0]   winner;
    logic         found;
    logic [1:0]   cand;
    logic         space;
    logic         load;
    logic [n-1:0] win_data;
    logic [1:0]   ptr_next;

    assign space = !out_valid || out_ready;
    assign load  = space && (req != 4'b0000);

    // Scan starting at the pointer so the most recently served requester is last.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        cand   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        case (winner)
            2'd0:    win_data = D0;
            2'd1:    win_data = D1;
            2'd2:    win_data = D2;
            default: win_data = D3;
        endcase
    end

`ifdef RR_MUX_LOCK_EN
    assign ptr_next = lock ? winner : winner + 2'd1;
`else
    assign ptr_next = winner + 2'd1;
`endif

    assign ack = (load && !rst) ? (4'b0001 << winner) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            sel       <= 2'd0;
            out_valid <= 1'b0;
            ptr       <= 2'd0;
        end else if (load) begin
            out       <= win_data;
            sel       <= winner;
            out_valid <= 1'b1;
            ptr       <= ptr_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - self-checking bench for rr_mux_arbiter against a behavioural model
module tb_rr_mux_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] dd [4];
    logic [3:0]  ack;
    logic [31:0] out;
    logic [1:0]  sel;
    logic        out_valid;
    logic        out_ready;
`ifdef RR_MUX_LOCK_EN
    logic        lock;
`endif

    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] m_out;
    int          m_sel;
    logic        m_valid;
    int          m_ptr;
    logic        m_lock;

    rr_mux_arbiter #(.n(32)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .D0(dd[0]),
        .D1(dd[1]),
        .D2(dd[2]),
        .D3(dd[3]),
`ifdef RR_MUX_LOCK_EN
        .lock(lock),
`endif
        .ack(ack),
        .out(out),
        .sel(sel),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] rq, input int p);
        int w = -1;
        for (int k = 0; k < 4; k++)
            if (w < 0 && rq[(p + k) % 4]) w = (p + k) % 4;
        return w;
    endfunction

    // One clock: apply inputs, check mid-cycle against the model, then advance the model at the edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic rdy,
                        input string tag, output int granted);
        logic [3:0] exp_ack;
        int w;
        rst = r; req = rq; out_ready = rdy;
        #3;
        w = (!r && (!m_valid || rdy)) ? pick(rq, m_ptr) : -1;
        exp_ack = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        chk({tag, ".ack"}, {28'd0, ack}, {28'd0, exp_ack});
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk({tag, ".out"}, out, m_out);
            chk({tag, ".sel"}, {30'd0, sel}, 32'(m_sel));
        end
        @(posedge clk);
        if (r) begin
            m_out = 0; m_sel = 0; m_valid = 0; m_ptr = 0;
        end else if (w >= 0) begin
            m_out = dd[w]; m_sel = w; m_valid = 1;
            m_ptr = m_lock ? w : (w + 1) % 4;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        granted = w;
        #1;
    endtask

    initial begin
        int g;
        logic [3:0] pend;
        m_out = 0; m_sel = 0; m_valid = 0; m_ptr = 0; m_lock = 0;
`ifdef RR_MUX_LOCK_EN
        lock = 1'b0;
`endif
        dd[0] = 32'h0; dd[1] = 32'h1; dd[2] = 32'hAAAAAAAA; dd[3] = 32'h80000001;
        rst = 1'b1; req = 4'b0; out_ready = 1'b0;
        @(posedge clk); #1;

        // reset held with all requests up
        step(1, 4'b1111, 1, "rst0", g);
        step(1, 4'b1111, 1, "rst1", g);
        chk("rst.out", out, 32'h0);
        chk("rst.sel", {30'd0, sel}, 32'd0);

        // fairness sweep 0,1,2,3,0
        for (int i = 0; i < 6; i++) begin
            step(0, 4'b1111, 1, "fair", g);
            if (i < 5) chk("fair.winner", 32'(g), 32'(i % 4));
        end
        step(0, 4'b0000, 1, "drain", g);

        // backpressure on requester 2
        step(0, 4'b0100, 0, "bp.load", g);
        chk("bp.first", 32'(g), 32'd2);
        for (int i = 0; i < 5; i++) step(0, 4'b0100, 0, "bp.hold", g);
        chk("bp.out", out, 32'hAAAAAAAA);
        step(0, 4'b0100, 1, "bp.release", g);
        chk("bp.again", 32'(g), 32'd2);

        // pointer now 3: wrap to 0, then 1, then pointer 2
        step(0, 4'b0011, 1, "wrap0", g);
        chk("wrap.first", 32'(g), 32'd0);
        step(0, 4'b0011, 1, "wrap1", g);
        chk("wrap.second", 32'(g), 32'd1);
        step(0, 4'b1111, 1, "wrap2", g);
        chk("wrap.ptr2", 32'(g), 32'd2);

        // reset with sel = 1 held
        step(0, 4'b0000, 1, "pre", g);
        step(0, 4'b0010, 1, "mid.load", g);
        step(1, 4'b1111, 0, "mid.rst", g);
        step(0, 4'b0000, 0, "mid.idle", g);
        step(0, 4'b1111, 1, "mid.after", g);
        chk("mid.grant0", 32'(g), 32'd0);
        step(0, 4'b0000, 1, "mid.drain", g);

`ifdef RR_MUX_LOCK_EN
        lock = 1'b1; m_lock = 1'b1;
        step(1, 4'b0000, 1, "lk.rst", g);
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b1010, 1, "lk.burst", g);
            chk("lk.sel1", 32'(g), 32'd1);
        end
        lock = 1'b0; m_lock = 1'b0;
        step(0, 4'b1010, 1, "lk.drop", g);
        step(0, 4'b1010, 1, "lk.next", g);
        chk("lk.grant3", 32'(g), 32'd3);
        step(0, 4'b0000, 1, "lk.drain", g);
`endif

        // randomized requesters that hold until acknowledged
        pend = 4'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    dd[i] = $urandom;
                end else if (pend[i] && ($urandom % 20 == 0)) begin
                    pend[i] = 1'b0;
                end
            end
            step(($urandom % 60) == 0, pend, ($urandom % 4) != 0, "rand", g);
            if (g >= 0) pend[g] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
